apb_slave_interface: RTL and testbench
======================================

// Module: apb_slave_interface
// PURPOSE
// - APB3 slave front-end of the SPI controller: APB handshake FSM plus the control/status/data register file.
// - Drives SPI config (mstr/cpol/cpha/lsbfe/prescalers) to the baud/shift logic.
// - Tracks spi_mode (run/wait/stop) and hands TX/RX bytes to the shifter.
// - Raises the SPI interrupt request.
// PARAMETERS
// - none (addresses and reset values are package constants)
// PORTS
// PCLK                  in   1  clock; all flops on rising edge
// PRESETn               in   1  reset: asynchronous, active-high (name kept per codebase)
// PSEL,PENABLE,PWRITE   in   1  APB controls
// PADDR                 in   3  register address
// PWDATA                in   8  write data
// ss                    in   1  slave-select line (active-low), feeds mode-fault detect
// receive_data          in   1  1-cycle strobe: shifter holds a received byte on miso_data
// tip                   in   1  transfer in progress
// miso_data             in   8  received byte
// mstr,cpol,cpha,lsbfe  out  1  CR1[4],CR1[3],CR1[2],CR1[0]
// spiswai               out  1  CR2[1]
// sppr,spr              out  3  BR[6:4], BR[2:0]
// spi_mode              out  2  00 run, 01 wait, 10 stop
// spi_interrupt_request out  1  interrupt
// PREADY,PSLVERR        out  1  APB response
// send_data             out  1  1-cycle TX-start strobe
// mosi_data             out  8  byte to transmit
// PRDATA                out  8  read data
// BEHAVIOUR
// - APB FSM (STATE, 2b), states: IDLE=00, SETUP=01, ENABLE=10.
//   - IDLE->SETUP on PSEL&!PENABLE.
//   - SETUP->ENABLE on PSEL&PENABLE; SETUP stays on PSEL&!PENABLE; else IDLE.
//   - ENABLE->SETUP if PSEL, else IDLE.
//   - Reset -> IDLE.
// - APB response: PREADY=(STATE==ENABLE); PSLVERR=(STATE==ENABLE)&tip. No wait states.
// - Strobes: wr_en=PWRITE&(STATE==ENABLE); rd_en=!PWRITE&(STATE==ENABLE).
// - Register map (addr / reset / write mask); unused addresses read 0 and ignore writes:
//   - 0 CR1 / 8'h04 / FF: spie[7] spe[6] sptie[5] mstr[4] cpol[3] cpha[2] ssoe[1] lsbfe[0]
//   - 1 CR2 / 8'h00 / 1B: modfen[4] bidiroe[3] spiswai[1] spc0[0]
//   - 2 BR  / 8'h00 / 77
//   - 3 SR  / 8'h20 / read-only: spif[7] sptef[5] modf[4]
//   - 5 DR  / 8'h00
// - Writes commit at the PCLK edge ending the ENABLE cycle.
// - PRDATA = addressed register while rd_en, else 8'h00 (combinational).
// - modf = ~ss & mstr & modfen & ~ssoe (combinational, visible in SR[4]).
// - DR write: DR<=PWDATA and sptef<=0.
//   - Next cycle, if spi_mode is run or wait: send_data=1 for one cycle, mosi_data<=DR, sptef<=1.
//   - In stop: TX stays pending until mode leaves stop.
// - receive_data while not stop: DR<=miso_data, spif<=1.
//   - DR read (rd_en, PADDR=5) clears spif.
//   - Same-cycle receive_data wins over the clear.
// - IRQ: spi_interrupt_request = (spie&(spif|modf)) | (sptie&sptef).
// - spi_mode FSM, reset=stop:
//   - stop: spe -> (spiswai ? wait : run).
//   - run: !spe -> stop; else spiswai -> wait.
//   - wait: !spe -> stop; else !spiswai -> run.
// - Reset mid-transfer: every register, STATE and spi_mode return to reset values at once; send_data=0, mosi_data=0.
// STRUCTURE
// - Package spi_apb_pkg: APB state enum, spi_mode enum, register addresses, reset values, write masks.
// - Sub-module spi_mode_ctrl: spi_mode FSM. Everything else lives in this module.
// TESTING
// 1. Reset -> STATE=00, spi_mode=10, PREADY=0, PRDATA=00, CR1=04, SR=20.
// 2. Write CR1=A5: PSEL 1 cycle, then PENABLE -> PREADY=1 in ENABLE; afterwards cpha=1, lsbfe=1, mstr=0, spi_mode stays 10, irq=1 (sptie&sptef).
// 3. Read SR (PADDR=3) in ENABLE -> PRDATA=20; STATE alternates SETUP/ENABLE while PSEL&PENABLE held.
// 4. CR1=40 (spe) -> spi_mode=00; CR2=02 -> 01; CR1=00 -> 10. CR2 write FF -> reads 1B; BR write FF -> reads 77.
// 5. spe=1, write DR=3C -> one-cycle send_data, mosi_data=3C, sptef back to 1.
// 6. receive_data with miso_data=F0 -> DR=F0, SR[7]=1; DR read -> clears spif. mstr=modfen=1, ssoe=0, ss=0 -> SR[4]=1, irq with spie. tip=1 in ENABLE -> PSLVERR=1.

Source files
------------

// File: rtl/apb_slave_interface_pkg.sv
// Shared types and constants for the SPI APB slave front-end:
// bus FSM states, SPI power modes, register addresses, reset values, write masks.
package spi_apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ENABLE = 2'b10
  } apb_state_e;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_WAIT = 2'b01,
    MODE_STOP = 2'b10
  } spi_mode_e;

  localparam logic [2:0] ADDR_CR1 = 3'd0;
  localparam logic [2:0] ADDR_CR2 = 3'd1;
  localparam logic [2:0] ADDR_BR  = 3'd2;
  localparam logic [2:0] ADDR_SR  = 3'd3;
  localparam logic [2:0] ADDR_DR  = 3'd5;

  localparam logic [7:0] CR1_RST = 8'h04;
  localparam logic [7:0] CR2_RST = 8'h00;
  localparam logic [7:0] BR_RST  = 8'h00;
  localparam logic [7:0] DR_RST  = 8'h00;

  localparam logic [7:0] CR1_MASK = 8'hFF;
  localparam logic [7:0] CR2_MASK = 8'h1B;
  localparam logic [7:0] BR_MASK  = 8'h77;

endpackage

// File: rtl/apb_slave_interface_if.sv
// APB3 bus bundle between the host master and the SPI register front-end.
interface apb_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [2:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_interface_spi_mode_ctrl.sv
// SPI power-mode tracker: stop until enabled, then run or wait depending
// on whether the block should idle while the CPU is in wait.
module spi_mode_ctrl
  import spi_apb_pkg::*;
(
  input  logic      PCLK,
  input  logic      PRESETn,
  input  logic      spe,
  input  logic      spiswai,
  output spi_mode_e spi_mode
);

  spi_mode_e mode_q, mode_d;

  // Next-mode decision from the enable and wait-stop control bits.
  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      MODE_STOP: if (spe) mode_d = spiswai ? MODE_WAIT : MODE_RUN;
      MODE_RUN: begin
        if (!spe)        mode_d = MODE_STOP;
        else if (spiswai) mode_d = MODE_WAIT;
      end
      MODE_WAIT: begin
        if (!spe)         mode_d = MODE_STOP;
        else if (!spiswai) mode_d = MODE_RUN;
      end
      default: mode_d = MODE_STOP;
    endcase
  end

  // Mode register; reset parks the block in stop.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) mode_q <= MODE_STOP;
    else         mode_q <= mode_d;
  end

  assign spi_mode = mode_q;

endmodule

// File: rtl/apb_slave_interface.sv
// APB3 slave front-end of the SPI controller: bus handshake FSM, the
// CR1/CR2/BR/SR/DR register file, TX/RX byte hand-off and interrupt request.
module apb_slave_interface
  import spi_apb_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESETn,   // active-high despite the name
  apb_if.slave        bus,
  input  logic        ss,
  input  logic        receive_data,
  input  logic        tip,
  input  logic [7:0]  miso_data,
  output logic        mstr,
  output logic        cpol,
  output logic        cpha,
  output logic        lsbfe,
  output logic        spiswai,
  output logic [2:0]  sppr,
  output logic [2:0]  spr,
  output logic [1:0]  spi_mode,
  output logic        spi_interrupt_request,
  output logic        send_data,
  output logic [7:0]  mosi_data
);

  apb_state_e state_q, state_d;
  spi_mode_e  mode;
  logic [7:0] cr1_q, cr1_d, cr2_q, cr2_d, br_q, br_d, dr_q, dr_d;
  logic [7:0] mosi_q, mosi_d;
  logic       spif_q, spif_d, sptef_q, sptef_d;
  logic       tx_pend_q, tx_pend_d, send_q, send_d;
  logic       wr_en, rd_en, modf, not_stop;
  logic [7:0] sr;

  // APB handshake next-state; no wait states are ever inserted.
  always_comb begin
    state_d = APB_IDLE;
    unique case (state_q)
      APB_IDLE:   state_d = (bus.PSEL && !bus.PENABLE) ? APB_SETUP : APB_IDLE;
      APB_SETUP: begin
        if (bus.PSEL && bus.PENABLE)  state_d = APB_ENABLE;
        else if (bus.PSEL)            state_d = APB_SETUP;
        else                          state_d = APB_IDLE;
      end
      APB_ENABLE: state_d = bus.PSEL ? APB_SETUP : APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  assign wr_en       = bus.PWRITE && (state_q == APB_ENABLE);
  assign rd_en       = !bus.PWRITE && (state_q == APB_ENABLE);
  assign bus.PREADY  = (state_q == APB_ENABLE);
  assign bus.PSLVERR = (state_q == APB_ENABLE) && tip;

  assign not_stop = (mode != MODE_STOP);
  assign modf     = ~ss & cr1_q[4] & cr2_q[4] & ~cr1_q[1];
  assign sr       = {spif_q, 1'b0, sptef_q, modf, 4'b0000};

  // Register-file update. Order matters: a TX launch is overridden by a
  // same-cycle DR write (which re-arms it), receive beats the read-clear of
  // spif, and a host DR write beats an incoming byte.
  always_comb begin
    cr1_d     = cr1_q;
    cr2_d     = cr2_q;
    br_d      = br_q;
    dr_d      = dr_q;
    spif_d    = spif_q;
    sptef_d   = sptef_q;
    tx_pend_d = tx_pend_q;
    mosi_d    = mosi_q;
    send_d    = 1'b0;
    if (tx_pend_q && not_stop) begin
      send_d    = 1'b1;
      mosi_d    = dr_q;
      sptef_d   = 1'b1;
      tx_pend_d = 1'b0;
    end
    if (rd_en && bus.PADDR == ADDR_DR) spif_d = 1'b0;
    if (receive_data && not_stop) begin
      dr_d   = miso_data;
      spif_d = 1'b1;
    end
    if (wr_en) begin
      unique case (bus.PADDR)
        ADDR_CR1: cr1_d = bus.PWDATA & CR1_MASK;
        ADDR_CR2: cr2_d = bus.PWDATA & CR2_MASK;
        ADDR_BR:  br_d  = bus.PWDATA & BR_MASK;
        ADDR_DR: begin
          dr_d      = bus.PWDATA;
          sptef_d   = 1'b0;
          tx_pend_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State and register flops; reset drops everything at once, mid-transfer included.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      state_q   <= APB_IDLE;
      cr1_q     <= CR1_RST;
      cr2_q     <= CR2_RST;
      br_q      <= BR_RST;
      dr_q      <= DR_RST;
      spif_q    <= 1'b0;
      sptef_q   <= 1'b1;
      tx_pend_q <= 1'b0;
      send_q    <= 1'b0;
      mosi_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      cr1_q     <= cr1_d;
      cr2_q     <= cr2_d;
      br_q      <= br_d;
      dr_q      <= dr_d;
      spif_q    <= spif_d;
      sptef_q   <= sptef_d;
      tx_pend_q <= tx_pend_d;
      send_q    <= send_d;
      mosi_q    <= mosi_d;
    end
  end

  // Read mux, only driven during a read ENABLE cycle.
  always_comb begin
    bus.PRDATA = 8'h00;
    if (rd_en) begin
      unique case (bus.PADDR)
        ADDR_CR1: bus.PRDATA = cr1_q;
        ADDR_CR2: bus.PRDATA = cr2_q;
        ADDR_BR:  bus.PRDATA = br_q;
        ADDR_SR:  bus.PRDATA = sr;
        ADDR_DR:  bus.PRDATA = dr_q;
        default:  bus.PRDATA = 8'h00;
      endcase
    end
  end

  spi_mode_ctrl u_mode (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .spe      (cr1_q[6]),
    .spiswai  (cr2_q[1]),
    .spi_mode (mode)
  );

  assign spi_mode  = mode;
  assign mstr      = cr1_q[4];
  assign cpol      = cr1_q[3];
  assign cpha      = cr1_q[2];
  assign lsbfe     = cr1_q[0];
  assign spiswai   = cr2_q[1];
  assign sppr      = br_q[6:4];
  assign spr       = br_q[2:0];
  assign send_data = send_q;
  assign mosi_data = mosi_q;
  assign spi_interrupt_request = (cr1_q[7] & (spif_q | modf)) | (cr1_q[5] & sptef_q);

endmodule

// File: tb/tb_apb_slave_interface.sv
module tb_apb_slave_interface;
  import spi_apb_pkg::*;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       ss, receive_data, tip;
  logic [7:0] miso_data;
  logic       mstr, cpol, cpha, lsbfe, spiswai;
  logic [2:0] sppr, spr;
  logic [1:0] spi_mode;
  logic       irq, send_data;
  logic [7:0] mosi_data;

  apb_if bus();

  apb_slave_interface dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus), .ss(ss),
    .receive_data(receive_data), .tip(tip), .miso_data(miso_data),
    .mstr(mstr), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe), .spiswai(spiswai),
    .sppr(sppr), .spr(spr), .spi_mode(spi_mode),
    .spi_interrupt_request(irq), .send_data(send_data), .mosi_data(mosi_data)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] rdata;
    logic       slverr;
    string      name;
  } apb_exp_t;

  apb_exp_t   apb_q[$];
  logic [7:0] tx_q[$];
  apb_exp_t   mon_e;
  logic [7:0] mon_tx;
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h", nm, act, exp);
  endtask

  // Monitor: pops an expectation whenever the DUT completes a transfer or launches a TX byte.
  always @(negedge PCLK) begin
    if (bus.PREADY === 1'b1) begin
      if (apb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_pready: PRDATA %02h with nothing expected", bus.PRDATA);
      end else begin
        mon_e = apb_q.pop_front();
        chk({mon_e.name, "_prdata"}, bus.PRDATA, mon_e.rdata);
        chk({mon_e.name, "_pslverr"}, 8'(bus.PSLVERR), 8'(mon_e.slverr));
      end
    end
    if (send_data === 1'b1) begin
      if (tx_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_send_data: mosi %02h with nothing expected", mosi_data);
      end else begin
        mon_tx = tx_q.pop_front();
        chk("tx_mosi", mosi_data, mon_tx);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // One APB transfer; n>1 holds PSEL&PENABLE so ENABLE repeats n times.
  task automatic apb_xfer(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rd, input logic exp_err, input int n,
                          input logic rx, input logic [7:0] rx_byte, input string nm);
    apb_exp_t e;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wdata;
    e.rdata = exp_rd; e.slverr = exp_err; e.name = nm;
    for (int i = 0; i < n; i++) apb_q.push_back(e);
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    for (int i = 0; i < 2 * n; i++) begin
      @(posedge PCLK); #1;
      if (i == 0 && rx) begin
        receive_data = 1'b1; miso_data = rx_byte;
      end else begin
        receive_data = 1'b0;
      end
    end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input string nm);
    apb_xfer(1'b1, a, d, 8'h00, 1'b0, 1, 1'b0, 8'h00, nm);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string nm);
    apb_xfer(1'b0, a, 8'h00, exp, 1'b0, 1, 1'b0, 8'h00, nm);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(posedge PCLK); #1;
    miso_data = b; receive_data = 1'b1;
    @(posedge PCLK); #1;
    receive_data = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    PRESETn = 1'b1; ss = 1'b1; receive_data = 1'b0; tip = 1'b0; miso_data = 8'h00;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = 3'd0; bus.PWDATA = 8'h00;

    // reset values
    idle(3);
    chk("rst_mode", 8'(spi_mode), 8'h02);
    chk("rst_pready", 8'(bus.PREADY), 8'h00);
    chk("rst_prdata", bus.PRDATA, 8'h00);
    chk("rst_cpha", 8'(cpha), 8'h01);
    chk("rst_send", 8'(send_data), 8'h00);
    chk("rst_irq", 8'(irq), 8'h00);
    @(negedge PCLK); PRESETn = 1'b0;
    rd(ADDR_CR1, 8'h04, "rst_cr1");
    rd(ADDR_SR, 8'h20, "rst_sr");

    // CR1 = A5
    wr(ADDR_CR1, 8'hA5, "wr_cr1_a5");
    idle(2);
    chk("a5_cpha", 8'(cpha), 8'h01);
    chk("a5_lsbfe", 8'(lsbfe), 8'h01);
    chk("a5_mstr", 8'(mstr), 8'h00);
    chk("a5_cpol", 8'(cpol), 8'h00);
    chk("a5_mode", 8'(spi_mode), 8'h02);
    chk("a5_irq", 8'(irq), 8'h01);

    // held PSEL&PENABLE: three ENABLE cycles
    apb_xfer(1'b0, ADDR_SR, 8'h00, 8'h20, 1'b0, 3, 1'b0, 8'h00, "hold_sr");

    // mode transitions and write masks
    wr(ADDR_CR1, 8'h40, "wr_spe");
    idle(2);
    chk("mode_run", 8'(spi_mode), 8'h00);
    wr(ADDR_CR2, 8'h02, "wr_swai");
    idle(2);
    chk("mode_wait", 8'(spi_mode), 8'h01);
    chk("spiswai", 8'(spiswai), 8'h01);
    wr(ADDR_CR1, 8'h00, "wr_spe0");
    idle(2);
    chk("mode_stop", 8'(spi_mode), 8'h02);
    wr(ADDR_CR2, 8'hFF, "wr_cr2_ff");
    rd(ADDR_CR2, 8'h1B, "rd_cr2");
    wr(ADDR_BR, 8'hFF, "wr_br_ff");
    rd(ADDR_BR, 8'h77, "rd_br");
    chk("br_pins", {1'b0, sppr, 1'b0, spr}, 8'h77);
    rd(3'd6, 8'h00, "rd_unused");

    // TX held while stopped, launched once enabled
    wr(ADDR_DR, 8'h11, "wr_dr_stop");
    idle(3);
    rd(ADDR_SR, 8'h00, "sr_tx_pending");
    tx_q.push_back(8'h11);
    wr(ADDR_CR1, 8'h40, "wr_spe_release");
    idle(4);
    chk("mode_wait2", 8'(spi_mode), 8'h01);
    rd(ADDR_SR, 8'h20, "sr_after_tx1");

    // TX while active
    tx_q.push_back(8'h3C);
    wr(ADDR_DR, 8'h3C, "wr_dr_3c");
    idle(4);
    chk("mosi_hold", mosi_data, 8'h3C);
    rd(ADDR_SR, 8'h20, "sr_after_tx2");

    // receive path and spif clear
    rx_pulse(8'hF0);
    rd(ADDR_SR, 8'hA0, "sr_spif");
    rd(ADDR_DR, 8'hF0, "rd_dr_f0");
    rd(ADDR_SR, 8'h20, "sr_cleared");

    // receive in the same cycle as the clearing read wins
    rx_pulse(8'h96);
    apb_xfer(1'b0, ADDR_DR, 8'h00, 8'h96, 1'b0, 1, 1'b1, 8'h5A, "rd_dr_race");
    rd(ADDR_SR, 8'hA0, "sr_race_spif");
    rd(ADDR_DR, 8'h5A, "rd_dr_5a");
    rd(ADDR_SR, 8'h20, "sr_cleared2");

    // mode fault and interrupt
    wr(ADDR_CR2, 8'h10, "wr_modfen");
    wr(ADDR_CR1, 8'hD0, "wr_cr1_d0");
    ss = 1'b0;
    rd(ADDR_SR, 8'h30, "sr_modf");
    chk("modf_irq", 8'(irq), 8'h01);
    chk("modf_mstr", 8'(mstr), 8'h01);
    chk("modf_mode", 8'(spi_mode), 8'h00);
    ss = 1'b1;
    #1;
    chk("irq_clear", 8'(irq), 8'h00);

    // slave error during transfer in progress
    tip = 1'b1;
    apb_xfer(1'b0, ADDR_CR1, 8'h00, 8'hD0, 1'b1, 1, 1'b0, 8'h00, "rd_tip");
    tip = 1'b0;

    // asynchronous reset in the middle of a transfer
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PADDR = ADDR_CR1;
    #2 PRESETn = 1'b1;
    #1;
    chk("arst_mode", 8'(spi_mode), 8'h02);
    chk("arst_mstr", 8'(mstr), 8'h00);
    chk("arst_cpha", 8'(cpha), 8'h01);
    chk("arst_mosi", mosi_data, 8'h00);
    chk("arst_pready", 8'(bus.PREADY), 8'h00);
    bus.PSEL = 1'b0;
    @(negedge PCLK); PRESETn = 1'b0;
    rd(ADDR_CR1, 8'h04, "post_rst_cr1");
    rd(ADDR_SR, 8'h20, "post_rst_sr");

    idle(3);
    chk("apb_q_drained", 8'(apb_q.size()), 8'h00);
    chk("tx_q_drained", 8'(tx_q.size()), 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
